// File: rtl/riscv_pkg.sv
// Shared types for the RISC-V fetch front end: instruction/PC words and the
// prefetch queue entry that pairs them.
package riscv_pkg;

  localparam int INSTR_W     = 32;
  localparam int PC_W        = 32;
  localparam int INSTR_BYTES = 4;

  typedef logic [INSTR_W-1:0] riscVDat;
  typedef logic [PC_W-1:0]    PC;

  typedef struct packed {
    riscVDat instr;
    PC       pc;
  } fetch_entry_t;

endpackage

// File: rtl/riscv_fetch_fifo.sv
// First-word-fall-through queue of fetch entries with flush; the head entry is
// visible on o_head whenever o_empty is low.
module riscv_fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_flush,
  input  logic                  i_push,
  input  fetch_entry_t          i_push_data,
  input  logic                  i_pop,
  output fetch_entry_t          o_head,
  output logic [$clog2(DEPTH):0] o_occ,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t   r_mem [DEPTH];
  logic [AW-1:0]  r_wptr;
  logic [AW-1:0]  r_rptr;
  logic [CW-1:0]  r_count;
  logic           w_push;
  logic           w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign w_pop   = i_pop & ~o_empty & ~i_flush;
  // A pop frees the slot in the same edge, so push into a full queue is legal.
  assign w_push  = i_push & (~o_full | w_pop) & ~i_flush;

  // NOTE: entry storage has no reset; only pointers and count define validity,
  // and the top zeroes its outputs while the queue is empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  assign o_head = r_mem[r_rptr];
  assign o_occ  = r_count;

endmodule

// File: rtl/riscv_fetch_unit.sv
// Instruction-fetch front end: PC, synchronous-read instruction memory with a
// loader port, and a prefetch queue feeding decode, with step/free-run and redirect.
module riscv_fetch_unit
  import riscv_pkg::*;
#(
  parameter int                  I_WIDTH    = INSTR_W,
  parameter int                  PC_WIDTH   = PC_W,
  parameter int                  IMEM_DEPTH = 2**15,
  parameter int                  FIFO_DEPTH = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          run_mode,
  input  logic                          redirect_valid,
  input  logic [PC_WIDTH-1:0]           redirect_pc,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
  input  logic [I_WIDTH-1:0]            imem_wdata,
  output logic                          instr_valid,
  input  logic                          instr_ready,
  output logic [I_WIDTH-1:0]            instr,
  output logic [PC_WIDTH-1:0]           instr_pc,
  output logic [PC_WIDTH-1:0]           fetch_pc,
  output logic                          fetch_err
);

  localparam int AW = $clog2(IMEM_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [I_WIDTH-1:0]  r_imem [IMEM_DEPTH];
  logic [I_WIDTH-1:0]  r_rdata;
  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] r_if_pc;
  logic                r_inflight;
  logic                r_en_del;
  logic                r_step_pend;
  logic                r_fetch_err;

  logic                w_redir_ok;
  logic                w_redir_bad;
  logic                w_step;
  logic                w_credit;
  logic                w_issue;
  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic [CW-1:0]       w_occ;
  logic [AW-1:0]       w_idx;
  fetch_entry_t        w_push_entry;
  fetch_entry_t        w_head;

  assign w_redir_ok  = redirect_valid & (redirect_pc[1:0] == 2'b00);
  assign w_redir_bad = redirect_valid & (redirect_pc[1:0] != 2'b00);
  assign w_step      = r_en_del & ~en;
  // Credit counts the read in flight so a full queue is never overrun.
  assign w_credit    = ~w_full & ((w_occ + CW'(r_inflight)) < CW'(FIFO_DEPTH));
  assign w_issue     = ~w_redir_ok & w_credit & (run_mode | w_step | r_step_pend);
  assign w_push      = r_inflight & ~w_redir_ok;
  assign w_pop       = instr_valid & instr_ready;
  assign w_idx       = r_pc[AW+1:2];

  always_ff @(posedge clk) begin
    if (imem_we) r_imem[imem_waddr] <= imem_wdata;
    if (w_issue) r_rdata <= r_imem[w_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc        <= RESET_PC;
      r_if_pc     <= '0;
      r_inflight  <= 1'b0;
      r_en_del    <= 1'b0;
      r_step_pend <= 1'b0;
      r_fetch_err <= 1'b0;
    end else begin
      r_en_del    <= en;
      r_fetch_err <= w_redir_bad;
      if (w_redir_ok) begin
        r_pc        <= redirect_pc;
        r_inflight  <= 1'b0;
        r_step_pend <= 1'b0;
      end else begin
        r_inflight <= w_issue;
        if (w_issue) begin
          r_pc        <= r_pc + PC_WIDTH'(INSTR_BYTES);
          r_if_pc     <= r_pc;
          r_step_pend <= 1'b0;
        end else if (~run_mode & w_step) begin
          r_step_pend <= 1'b1;
        end
      end
    end
  end

  assign w_push_entry.instr = r_rdata;
  assign w_push_entry.pc    = r_if_pc;

  riscv_fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_flush     (w_redir_ok),
    .i_push      (w_push),
    .i_push_data (w_push_entry),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_occ       (w_occ),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  assign instr_valid = ~w_empty;
  assign instr       = w_empty ? '0 : w_head.instr;
  assign instr_pc    = w_empty ? '0 : w_head.pc;
  assign fetch_pc    = r_pc;
  assign fetch_err   = r_fetch_err;

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Self-checking bench for riscv_fetch_unit: delivered instructions are compared
// against a stream model built from shadow memory and redirect history.
module tb_riscv_fetch_unit;

  localparam int AW    = 15;
  localparam int DEPTH = 2**AW;
  localparam int NLOAD = 1024;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          run_mode = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [31:0]   redirect_pc = '0;
  logic          imem_we = 1'b0;
  logic [AW-1:0] imem_waddr = '0;
  logic [31:0]   imem_wdata = '0;
  logic          instr_ready = 1'b0;
  logic          instr_valid;
  logic [31:0]   instr;
  logic [31:0]   instr_pc;
  logic [31:0]   fetch_pc;
  logic          fetch_err;

  riscv_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en             (en),
    .run_mode       (run_mode),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_we        (imem_we),
    .imem_waddr     (imem_waddr),
    .imem_wdata     (imem_wdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .fetch_pc       (fetch_pc),
    .fetch_err      (fetch_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] shadow [DEPTH];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] exp_pc;
  } del_t;
  del_t        got[$];
  logic [31:0] model_pc;

  // Stream model: every accepted instruction follows its predecessor by 4
  // bytes, except that an aligned redirect restarts the stream at its target.
  always @(negedge clk) begin
    if (!rst_n) begin
      model_pc = 32'h0;
    end else begin
      if (instr_valid && instr_ready) begin
        got.push_back('{instr_pc, instr, model_pc});
        model_pc = model_pc + 32'd4;
      end
      if (redirect_valid && redirect_pc[1:0] == 2'b00) model_pc = redirect_pc;
    end
  end

  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    logic [AW-1:0] idx;
    idx = pc[AW+1:2];
    return shadow[idx];
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input logic rm, input logic rdy);
    rst_n = 1'b0;
    en = 1'b0;
    redirect_valid = 1'b0;
    imem_we = 1'b0;
    run_mode = rm;
    instr_ready = rdy;
    tick(2);
    got.delete();
    rst_n = 1'b1;
  endtask

  task automatic load_mem();
    for (int i = 0; i < NLOAD; i++) begin
      imem_we = 1'b1;
      imem_waddr = AW'(i);
      imem_wdata = $urandom;
      shadow[i] = imem_wdata;
      tick();
    end
    imem_we = 1'b0;
  endtask

  task automatic test_free_run();
    do_reset(1'b1, 1'b1);
    tick();
    if (instr_valid !== 1'b0) begin
      $display("FAIL fr_valid_edge1: got %b want 0", instr_valid); n_bad++;
    end
    n_cmp++;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (instr_valid !== 1'b1 || instr_pc !== 32'(4*k) || instr !== shadow[k]) begin
        $display("FAIL fr_seq[%0d]: got v=%b pc=%h i=%h want v=1 pc=%h i=%h",
                 k, instr_valid, instr_pc, instr, 32'(4*k), shadow[k]);
        n_bad++;
      end
      n_cmp++;
    end
  endtask

  task automatic test_reset();
    tick(3);
    #2 rst_n = 1'b0;
    #1;
    if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0) begin
      $display("FAIL rst_out: got v=%b i=%h pc=%h want 0/0/0", instr_valid, instr, instr_pc);
      n_bad++;
    end
    n_cmp++;
    if (fetch_pc !== 32'h0 || fetch_err !== 1'b0) begin
      $display("FAIL rst_pc: got fetch_pc=%h err=%b want 0/0", fetch_pc, fetch_err);
      n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_step();
    do_reset(1'b0, 1'b1);
    tick(3);
    if (instr_valid !== 1'b0 || fetch_pc !== 32'h0) begin
      $display("FAIL step_idle: got v=%b fetch_pc=%h want 0/0", instr_valid, fetch_pc);
      n_bad++;
    end
    n_cmp++;
    for (int s = 0; s < 3; s++) begin
      en = 1'b1;
      tick();
      en = 1'b0;
      tick(4 + int'($urandom_range(0, 2)));
      if (fetch_pc !== 32'(4*(s+1))) begin
        $display("FAIL step_fetch_pc[%0d]: got %h want %h", s, fetch_pc, 32'(4*(s+1)));
        n_bad++;
      end
      n_cmp++;
    end
    tick(2);
    if (got.size() != 3) begin
      $display("FAIL step_count: got %0d want 3", got.size()); n_bad++;
    end
    n_cmp++;
    for (int i = 0; i < got.size() && i < 3; i++) begin
      if (got[i].pc !== 32'(4*i) || got[i].ins !== shadow[i]) begin
        $display("FAIL step_data[%0d]: got pc=%h i=%h want pc=%h i=%h",
                 i, got[i].pc, got[i].ins, 32'(4*i), shadow[i]);
        n_bad++;
      end
      n_cmp++;
    end
  endtask

  task automatic test_backpressure();
    do_reset(1'b1, 1'b0);
    tick(8);
    if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || fetch_pc !== 32'h10) begin
      $display("FAIL bp_full: got v=%b pc=%h fetch_pc=%h want 1/0/10",
               instr_valid, instr_pc, fetch_pc);
      n_bad++;
    end
    n_cmp++;
    tick(3);
    if (instr_pc !== 32'h0 || instr !== shadow[0] || fetch_pc !== 32'h10) begin
      $display("FAIL bp_hold: got pc=%h i=%h fetch_pc=%h want 0/%h/10",
               instr_pc, instr, fetch_pc, shadow[0]);
      n_bad++;
    end
    n_cmp++;
    instr_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (instr_valid !== 1'b1) begin
        $display("FAIL bp_gap[%0d]: got valid=%b want 1", c, instr_valid); n_bad++;
      end
      n_cmp++;
    end
    if (got.size() < 6) begin
      $display("FAIL bp_count: got %0d want >=6", got.size()); n_bad++;
    end
    n_cmp++;
    for (int i = 0; i < got.size() && i < 6; i++) begin
      if (got[i].pc !== 32'(4*i) || got[i].ins !== shadow[i]) begin
        $display("FAIL bp_seq[%0d]: got pc=%h i=%h want pc=%h i=%h",
                 i, got[i].pc, got[i].ins, 32'(4*i), shadow[i]);
        n_bad++;
      end
      n_cmp++;
    end
  endtask

  task automatic test_redirect();
    do_reset(1'b1, 1'b0);
    tick(4);
    if (fetch_pc !== 32'h10 || instr_valid !== 1'b1) begin
      $display("FAIL redir_pre: got fetch_pc=%h v=%b want 10/1", fetch_pc, instr_valid);
      n_bad++;
    end
    n_cmp++;
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    tick();
    redirect_valid = 1'b0;
    if (instr_valid !== 1'b0 || fetch_pc !== 32'h40) begin
      $display("FAIL redir_flush: got v=%b fetch_pc=%h want 0/40", instr_valid, fetch_pc);
      n_bad++;
    end
    n_cmp++;
    got.delete();
    instr_ready = 1'b1;
    tick(6);
    if (got.size() < 3) begin
      $display("FAIL redir_count: got %0d want >=3", got.size()); n_bad++;
    end
    n_cmp++;
    foreach (got[i]) begin
      if (got[i].pc !== 32'h40 + 32'(4*i) || got[i].ins !== mem_word(got[i].pc)) begin
        $display("FAIL redir_seq[%0d]: got pc=%h i=%h want pc=%h i=%h", i, got[i].pc,
                 got[i].ins, 32'h40 + 32'(4*i), mem_word(32'h40 + 32'(4*i)));
        n_bad++;
      end
      n_cmp++;
    end
  endtask

  task automatic test_fetch_err();
    do_reset(1'b1, 1'b1);
    tick(5);
    got.delete();
    redirect_valid = 1'b1;
    redirect_pc = 32'h42;
    tick();
    redirect_valid = 1'b0;
    if (fetch_err !== 1'b1) begin
      $display("FAIL ferr_pulse: got %b want 1", fetch_err); n_bad++;
    end
    n_cmp++;
    tick();
    if (fetch_err !== 1'b0) begin
      $display("FAIL ferr_clear: got %b want 0", fetch_err); n_bad++;
    end
    n_cmp++;
    tick(4);
    if (got.size() < 4) begin
      $display("FAIL ferr_count: got %0d want >=4", got.size()); n_bad++;
    end
    n_cmp++;
    foreach (got[i]) begin
      if (got[i].pc !== got[i].exp_pc || got[i].ins !== mem_word(got[i].exp_pc)) begin
        $display("FAIL ferr_seq[%0d]: got pc=%h i=%h want pc=%h i=%h", i, got[i].pc,
                 got[i].ins, got[i].exp_pc, mem_word(got[i].exp_pc));
        n_bad++;
      end
      n_cmp++;
    end
  endtask

  task automatic test_loader_collision();
    logic [31:0] old_word;
    logic        found;
    do_reset(1'b1, 1'b1);
    tick(5);
    old_word = shadow[5];
    imem_we = 1'b1;
    imem_waddr = AW'(5);
    imem_wdata = 32'hDEADBEEF;
    tick();
    imem_we = 1'b0;
    shadow[5] = 32'hDEADBEEF;
    if (fetch_pc !== 32'h18) begin
      $display("FAIL ld_issue: got fetch_pc=%h want 18", fetch_pc); n_bad++;
    end
    n_cmp++;
    tick(4);
    found = 1'b0;
    foreach (got[i]) begin
      if (got[i].pc === 32'h14 && !found) begin
        found = 1'b1;
        if (got[i].ins !== old_word) begin
          $display("FAIL ld_old: got %h want %h", got[i].ins, old_word); n_bad++;
        end
        n_cmp++;
      end
    end
    if (!found) begin
      $display("FAIL ld_old_seen: pc 14 not delivered"); n_bad++;
      n_cmp++;
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h14;
    tick();
    redirect_valid = 1'b0;
    got.delete();
    tick(4);
    if (got.size() < 1 || got[0].pc !== 32'h14 || got[0].ins !== 32'hDEADBEEF) begin
      $display("FAIL ld_new: got n=%0d pc=%h i=%h want pc=14 i=deadbeef", got.size(),
               got.size() > 0 ? got[0].pc : 32'h0, got.size() > 0 ? got[0].ins : 32'h0);
      n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_random();
    logic        exp_err;
    logic        hv, hr, hd;
    logic [31:0] hp, hi;
    do_reset(1'b1, 1'b1);
    for (int c = 0; c < 300; c++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      run_mode = ($urandom_range(0, 7) != 0);
      en = 1'($urandom_range(0, 1));
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      if ($urandom_range(0, 3) == 0) redirect_pc[1:0] = 2'($urandom_range(1, 3));
      exp_err = redirect_valid && (redirect_pc[1:0] != 2'b00);
      hv = instr_valid; hr = instr_ready; hp = instr_pc; hi = instr;
      hd = redirect_valid && (redirect_pc[1:0] == 2'b00);
      tick();
      if (fetch_err !== exp_err) begin
        $display("FAIL rnd_err[%0d]: got %b want %b", c, fetch_err, exp_err); n_bad++;
      end
      n_cmp++;
      if (hv && !hr && !hd) begin
        if (instr_valid !== 1'b1 || instr_pc !== hp || instr !== hi) begin
          $display("FAIL rnd_hold[%0d]: got v=%b pc=%h i=%h want 1/%h/%h",
                   c, instr_valid, instr_pc, instr, hp, hi);
          n_bad++;
        end
        n_cmp++;
      end
    end
    redirect_valid = 1'b0;
    if (got.size() < 50) begin
      $display("FAIL rnd_count: got %0d want >=50", got.size()); n_bad++;
    end
    n_cmp++;
    foreach (got[i]) begin
      if (got[i].pc !== got[i].exp_pc || got[i].ins !== mem_word(got[i].exp_pc)) begin
        $display("FAIL rnd_seq[%0d]: got pc=%h i=%h want pc=%h i=%h", i, got[i].pc,
                 got[i].ins, got[i].exp_pc, mem_word(got[i].exp_pc));
        n_bad++;
      end
      n_cmp++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    load_mem();
    test_free_run();
    test_reset();
    test_step();
    test_backpressure();
    test_redirect();
    test_fetch_err();
    test_loader_collision();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
